// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_ctrl
// Purpose  : Synchronise, debounce and edge-detect four push-buttons; generate
//            auto-repeating press pulses and own the clk_mode state machine.
// Revision : 1.0  initial release
// ============================================================================
module button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_raw,
  input  logic       btn1_raw,
  input  logic       btn2_raw,
  input  logic       btn3_raw,
  output logic [1:0] clk_mode,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       setampm,
  output logic       mode_change
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_TIME  = 2'b01;
  localparam logic [1:0] MODE_ALARM = 2'b10;
  localparam logic [1:0] MODE_DATE  = 2'b11;

  // Index 0 is the mode button, 1..3 are button1..button3.
  logic [3:0] raw;
  logic [3:0] stable;
  logic [3:0] stable_dly;
  logic [3:0] rise;
  logic [2:0] hold_done;
  logic [2:1] rep_fire;

  assign raw = {btn3_raw, btn2_raw, btn1_raw, btn_mode_raw};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d, stable_dly_q;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == DEB_LAST) begin
          stable_d = ~stable_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= raw[i];
        sync2_q      <= sync1_q;
        stable_q     <= stable_d;
        stable_dly_q <= stable_q;
        cnt_q        <= cnt_d;
      end
    end

    assign stable[i]     = stable_q;
    assign stable_dly[i] = stable_dly_q;
    assign rise[i]       = stable_q & ~stable_dly_q;
  end

  // Hold counters saturate at HOLD_CYCLES; hold_done stays high while still pressed.
  for (genvar i = 0; i < 3; i++) begin : g_hold
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = '0;
      if (stable[i]) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    assign hold_done[i] = stable[i] & (hold_q == HOLD_MAX);
  end

  // Repeat phase 0 fires, so the first repeat coincides with the hold threshold.
  for (genvar i = 1; i < 3; i++) begin : g_rep
    logic [RW-1:0] rep_q, rep_d;

    always_comb begin
      rep_d = '0;
      if (hold_done[i]) begin
        rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    assign rep_fire[i] = hold_done[i] & (rep_q == '0);
  end

  logic [1:0] mode_q, mode_d;
  logic       long_q, long_d;
  logic       long_fire, mode_fall;
  logic       setampm_q, setampm_d;
  logic       mode_change_q, mode_change_d;
  logic       button1_q, button2_q, button3_q;

  assign long_fire = hold_done[0] & ~long_q;
  assign mode_fall = stable_dly[0] & ~stable[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= MODE_RUN;
      long_q        <= 1'b0;
      setampm_q     <= 1'b0;
      mode_change_q <= 1'b0;
      button1_q     <= 1'b0;
      button2_q     <= 1'b0;
      button3_q     <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      long_q        <= long_d;
      setampm_q     <= setampm_d;
      mode_change_q <= mode_change_d;
      button1_q     <= rise[1] | rep_fire[1];
      button2_q     <= rise[2] | rep_fire[2];
      button3_q     <= rise[3];
    end
  end

  always_comb begin
    mode_d = mode_q;
    long_d = long_q;
    if (rise[0]) begin
      long_d = 1'b0;
    end
    if (long_fire) begin
      long_d = 1'b1;
      if (mode_q != MODE_RUN) begin
        mode_d = MODE_RUN;
      end
    end else if (mode_fall && !long_q) begin
      case (mode_q)
        MODE_RUN:   mode_d = MODE_TIME;
        MODE_TIME:  mode_d = MODE_ALARM;
        MODE_ALARM: mode_d = MODE_DATE;
        default:    mode_d = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    setampm_d     = long_fire & (mode_q == MODE_RUN);
    mode_change_d = (mode_d != mode_q);
  end

  assign clk_mode    = mode_q;
  assign setampm     = setampm_q;
  assign mode_change = mode_change_q;
  assign button1     = button1_q;
  assign button2     = button2_q;
  assign button3     = button3_q;

endmodule
`default_nettype wire
